seq_detector_prog: RTL and testbench

Runtime-programmable serial bit-sequence detector for the FSM exercise set. It generalises fixed-pattern shift-register detectors to any pattern length from 1 to MAX_LEN, with a per-bit don't-care mask and selectable overlapping or non-overlapping matching. It adds an input-valid qualifier and a saturating match counter. It sits between a serial bit source and control or statistics logic.

---
 rtl/seq_detector_prog_if.sv | 26 ++
 rtl/seq_detector_prog.sv | 56 +++++
 tb/tb_seq_detector_prog.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if: configuration, serial-bit and result signals of the
// programmable sequence detector.
interface seq_detector_prog_if #(
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 8
);
   localparam int LW = $clog2(MAX_LEN + 1);
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [MAX_LEN-1:0] cfg_mask;
   logic [LW-1:0]      cfg_len;
   logic               cfg_overlap;
   logic               bit_valid;
   logic               new_bit;
   logic               armed;
   logic               detected;
   logic [CNT_W-1:0]   match_count;
   modport master (
      output cfg_load, cfg_pattern, cfg_mask, cfg_len, cfg_overlap, bit_valid, new_bit,
      input  armed, detected, match_count
   );
   modport slave (
      input  cfg_load, cfg_pattern, cfg_mask, cfg_len, cfg_overlap, bit_valid, new_bit,
      output armed, detected, match_count
   );
endinterface

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable masked serial pattern detector with
// overlap control and a saturating match counter.
module seq_detector_prog #(
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 8
) (
   input logic               clk,
   input logic               rst,
   seq_detector_prog_if.slave bus
);
   localparam int LW = $clog2(MAX_LEN + 1);
   logic [MAX_LEN-1:0] pattern, mask, hist, next_hist, len_mask;
   logic [LW-1:0]      len, fill, next_fill, len_clamped;
   logic               overlap, arm, det, hit;
   logic [CNT_W-1:0]   count;
   // fill counts fresh bits since load (or since a non-overlapping match), capped at len
   always_comb begin
      next_hist   = {hist[MAX_LEN-2:0], bus.new_bit};
      next_fill   = (fill == len) ? fill : fill + 1'b1;
      len_mask    = ~({MAX_LEN{1'b1}} << len);
      hit         = arm && next_fill == len && ((next_hist ^ pattern) & mask & len_mask) == '0;
      len_clamped = (bus.cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.cfg_len;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pattern <= '0;
         mask    <= '0;
         len     <= '0;
         hist    <= '0;
         fill    <= '0;
         overlap <= 1'b1;
         arm     <= 1'b0;
         det     <= 1'b0;
         count   <= '0;
      end else if (bus.cfg_load) begin
         pattern <= bus.cfg_pattern;
         mask    <= bus.cfg_mask;
         overlap <= bus.cfg_overlap;
         len     <= len_clamped;
         hist    <= '0;
         fill    <= '0;
         count   <= '0;
         det     <= 1'b0;
         arm     <= len_clamped != '0;
      end else begin
         det <= bus.bit_valid && hit;
         if (bus.bit_valid) begin
            hist <= next_hist;
            fill <= (hit && !overlap) ? '0 : next_fill;
            if (hit && !(&count)) count <= count + 1'b1;
         end
      end
   assign bus.armed       = arm;
   assign bus.detected    = det;
   assign bus.match_count = count;
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed and random stimulus on two detector instances
// (8-bit and 2-bit counters) checked every cycle against a queue-based model.
module tb_seq_detector_prog;
   localparam int MAX = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic cfg_load = 1'b0, cfg_overlap = 1'b1, bit_valid = 1'b0, new_bit = 1'b0;
   logic [MAX-1:0] cfg_pattern = '0, cfg_mask = '0;
   logic [4:0] cfg_len = '0;
   int n_checks = 0, n_fail = 0;
   seq_detector_prog_if #(.MAX_LEN(MAX), .CNT_W(8)) b8 ();
   seq_detector_prog_if #(.MAX_LEN(MAX), .CNT_W(2)) b2 ();
   assign {b8.cfg_load, b8.cfg_overlap, b8.bit_valid, b8.new_bit} = {cfg_load, cfg_overlap, bit_valid, new_bit};
   assign {b2.cfg_load, b2.cfg_overlap, b2.bit_valid, b2.new_bit} = {cfg_load, cfg_overlap, bit_valid, new_bit};
   assign {b8.cfg_pattern, b8.cfg_mask, b8.cfg_len} = {cfg_pattern, cfg_mask, cfg_len};
   assign {b2.cfg_pattern, b2.cfg_mask, b2.cfg_len} = {cfg_pattern, cfg_mask, cfg_len};
   seq_detector_prog #(.MAX_LEN(MAX), .CNT_W(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
   seq_detector_prog #(.MAX_LEN(MAX), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
   always #5 clk = ~clk;
   // reference: fresh bits since load / non-overlapping match, newest at the back
   bit q[$];
   int m_len, m_cnt8, m_cnt2;
   logic [MAX-1:0] m_pat, m_mask;
   bit m_ovl, m_armed, m_det, m_ok;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete(); m_len = 0; m_pat = '0; m_mask = '0; m_ovl = 1;
         m_armed = 0; m_det = 0; m_cnt8 = 0; m_cnt2 = 0;
      end else if (cfg_load) begin
         q.delete();
         m_len = (int'(cfg_len) > MAX) ? MAX : int'(cfg_len);
         m_pat = cfg_pattern; m_mask = cfg_mask; m_ovl = cfg_overlap;
         m_armed = m_len != 0; m_det = 0; m_cnt8 = 0; m_cnt2 = 0;
      end else if (bit_valid) begin
         q.push_back(new_bit);
         if (q.size() > MAX) void'(q.pop_front());
         m_ok = m_armed && q.size() >= m_len;
         for (int i = 0; i < m_len; i++)
            if (m_ok && m_mask[i] && q[q.size()-1-i] != m_pat[i]) m_ok = 0;
         m_det = m_ok;
         if (m_ok) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            if (!m_ovl) q.delete();
         end
      end else m_det = 0;
   end
   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      check("armed8", int'(b8.armed), int'(m_armed));
      check("det8", int'(b8.detected), int'(m_det));
      check("count8", int'(b8.match_count), m_cnt8);
      check("armed2", int'(b2.armed), int'(m_armed));
      check("det2", int'(b2.detected), int'(m_det));
      check("count2", int'(b2.match_count), m_cnt2);
   end
   task automatic step(bit v, bit b, bit ld);
      @(negedge clk);
      bit_valid = v; new_bit = b; cfg_load = ld;
      @(posedge clk);
      #1;
      cfg_load = 0; bit_valid = 0;
   endtask
   task automatic load(logic [MAX-1:0] pat, logic [MAX-1:0] msk, int len, bit ovl);
      cfg_pattern = pat; cfg_mask = msk; cfg_len = 5'(len); cfg_overlap = ovl;
      step(0, 0, 1);
   endtask
   task automatic run(string name, string bits, string pulses);
      for (int i = 0; i < bits.len(); i++) begin
         step(1, bits[i] == "1", 0);
         check(name, int'(b8.detected), int'(pulses[i] == "1"));
      end
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check("rst_armed", int'(b8.armed), 0);
      check("rst_count", int'(b8.match_count), 0);
      rst = 0;
      // 110011 overlapping
      load(16'b110011, '1, 6, 1);
      run("t1", "01100110011", "00000010001");
      check("t1_count", int'(b8.match_count), 2);
      // overlap vs non-overlap
      load(16'b1010, '1, 4, 1);
      run("t2o", "10101010", "00010101");
      check("t2o_count", int'(b8.match_count), 3);
      load(16'b1010, '1, 4, 0);
      run("t2n", "10101010", "00010001");
      check("t2n_count", int'(b8.match_count), 2);
      // mask 1x01 with valid gaps
      load(16'b1001, 16'b1011, 4, 1);
      run("t3a", "11", "00"); repeat (3) step(0, 0, 0); run("t3a", "01", "01");
      load(16'b1001, 16'b1011, 4, 1);
      run("t3b", "10", "00"); repeat (3) step(0, 0, 0); run("t3b", "01", "01");
      load(16'b1001, 16'b1011, 4, 1);
      run("t3c", "01", "00"); repeat (3) step(0, 0, 0); run("t3c", "01", "00");
      // load colliding with the completing bit
      load(16'b110011, '1, 6, 1);
      run("t4a", "11001", "00000");
      step(1, 1, 1);
      check("t4_load_det", int'(b8.detected), 0);
      check("t4_load_cnt", int'(b8.match_count), 0);
      run("t4b", "110011", "000001");
      load('0, '0, 0, 1);
      check("t4_len0_armed", int'(b8.armed), 0);
      run("t4c", "101101", "000000");
      check("t4_len0_cnt", int'(b8.match_count), 0);
      load(16'hA5C3, '1, MAX + 3, 1);
      check("t4_clamp_armed", int'(b8.armed), 1);
      for (int i = MAX - 1; i >= 0; i--) begin
         step(1, cfg_pattern[i], 0);
         check("t4_clamp_det", int'(b8.detected), int'(i == 0));
      end
      // saturation
      load('0, '0, 1, 1);
      for (int k = 1; k <= 6; k++) begin
         step(1, 1'($urandom), 0);
         check("t5_det", int'(b2.detected), 1);
         check("t5_cnt2", int'(b2.match_count), (k < 3) ? k : 3);
         check("t5_cnt8", int'(b8.match_count), k);
      end
      // asynchronous reset mid-stream
      load(16'b110011, '1, 6, 1);
      run("t6a", "110", "000");
      #2 rst = 1;
      #1;
      check("t6_armed", int'(b8.armed), 0);
      check("t6_det", int'(b8.detected), 0);
      check("t6_cnt", int'(b2.match_count), 0);
      #3 rst = 0;
      run("t6b", "110011", "000000");
      check("t6_after_armed", int'(b8.armed), 0);
      // random traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 24) == 0) begin
            cfg_pattern = MAX'($urandom);
            cfg_mask    = MAX'($urandom | $urandom);
            cfg_len     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 5));
            cfg_overlap = 1'($urandom);
            step(1'($urandom), 1'($urandom), 1);
         end else step($urandom_range(0, 3) != 0, 1'($urandom), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
